// File: rtl/ahb_lite_initiator.sv
// AHB-Lite single-transfer initiator with a two-slot (address/data) pipeline.
// Optional alignment checking: define AHB_LITE_INITIATOR_ALIGN_CHK_EN.
module ahb_lite_initiator #(
    parameter int   ADDR_WIDTH = 12,
    parameter int   DATA_WIDTH = 32,
    parameter logic NONSEC     = 1'b0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [2:0]            HSIZE,
    output logic                  HWRITE,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic                  HNONSEC,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam int         MAX_SIZE  = $clog2(DATA_WIDTH / 8);

    logic                  a_vld_q, a_vld_d;
    logic                  a_cxl_q, a_cxl_d;
    logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
    logic                  d_vld_q, d_vld_d;
    logic                  d_cxl_q, d_cxl_d;
    logic                  d_write_q, d_write_d;
    logic [1:0]            htrans_q, htrans_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic [2:0]            hsize_q, hsize_d;
    logic                  hwrite_q, hwrite_d;
    logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic err1;
    logic accept;
    logic a_move;
    logic d_done;
    logic req_bad;

    // first cycle of a two-cycle ERROR response
    assign err1      = d_vld_q & HRESP & ~HREADY;
    assign req_ready = ~a_vld_q | (HREADY & ~err1);
    assign accept    = req_valid & req_ready;
    assign a_move    = a_vld_q & HREADY & ~err1;
    assign d_done    = d_vld_q & HREADY;

`ifdef AHB_LITE_INITIATOR_ALIGN_CHK_EN
    logic [ADDR_WIDTH+7:0] addr_x;
    assign addr_x = {8'b0, req_addr};

    // flag oversize or misaligned requests; they never reach the bus
    always_comb begin
        req_bad = (req_size > 3'(MAX_SIZE));
        for (int i = 0; i < 7; i++) begin
            if ((i < int'(req_size)) && addr_x[i]) begin
                req_bad = 1'b1;
            end
        end
    end
`else
    assign req_bad = 1'b0;
`endif

    // next-state: pipeline advance, cancellation and response capture
    always_comb begin
        a_vld_d     = a_vld_q;
        a_cxl_d     = a_cxl_q;
        a_wdata_d   = a_wdata_q;
        d_vld_d     = d_vld_q;
        d_cxl_d     = d_cxl_q;
        d_write_d   = d_write_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hsize_d     = hsize_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = d_done;
        rsp_err_d   = d_done & (d_cxl_q | HRESP);
        rsp_rdata_d = '0;

        if (d_done && !d_write_q && !d_cxl_q && !HRESP) begin
            rsp_rdata_d = HRDATA;
        end

        if (d_done) begin
            d_vld_d = 1'b0;
        end

        if (a_move) begin
            d_vld_d   = 1'b1;
            d_cxl_d   = a_cxl_q;
            d_write_d = hwrite_q;
            hwdata_d  = a_wdata_q;
            a_vld_d   = 1'b0;
            htrans_d  = TR_IDLE;
        end

        // retract the pending address phase during the first error cycle
        if (err1 && a_vld_q) begin
            a_cxl_d  = 1'b1;
            htrans_d = TR_IDLE;
        end

        if (accept) begin
            a_vld_d   = 1'b1;
            a_cxl_d   = req_bad;
            a_wdata_d = req_wdata;
            haddr_d   = req_addr;
            hsize_d   = req_size;
            hwrite_d  = req_write;
            htrans_d  = req_bad ? TR_IDLE : TR_NONSEQ;
        end
    end

    // state and output registers with synchronous reset
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_vld_q     <= 1'b0;
            a_cxl_q     <= 1'b0;
            a_wdata_q   <= '0;
            d_vld_q     <= 1'b0;
            d_cxl_q     <= 1'b0;
            d_write_q   <= 1'b0;
            htrans_q    <= TR_IDLE;
            haddr_q     <= '0;
            hsize_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            a_vld_q     <= a_vld_d;
            a_cxl_q     <= a_cxl_d;
            a_wdata_q   <= a_wdata_d;
            d_vld_q     <= d_vld_d;
            d_cxl_q     <= d_cxl_d;
            d_write_q   <= d_write_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hsize_q     <= hsize_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign HTRANS    = htrans_q;
    assign HADDR     = haddr_q;
    assign HSIZE     = hsize_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign HNONSEC   = NONSEC;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_initiator.sv
// Directed self-checking bench for ahb_lite_initiator.
// Cycle-scripted slave responses; define AHB_LITE_INITIATOR_ALIGN_CHK_EN to test that option.
module tb_ahb_lite_initiator;

    logic        HCLK;
    logic        HRESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] HADDR;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic        HNONSEC;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int errors = 0;
    int checks = 0;

    ahb_lite_initiator #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NONSEC(1'b0)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HSIZE(HSIZE), .HWRITE(HWRITE), .HTRANS(HTRANS),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HNONSEC(HNONSEC),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    task automatic drive_idle();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_size = 3'b010; req_wdata = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    endtask

    task automatic drive_req(input logic w, input logic [11:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_write = w; req_addr = a; req_size = 3'b010; req_wdata = d;
    endtask

    task automatic settle();
        drive_idle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        drive_idle();
        HRESET = 1'b1;
        repeat (3) tick();
        HRESET = 1'b0;
        #1;
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans got %b want 00", HTRANS); end
        checks++; if (HADDR !== 12'h0) begin errors++; $display("FAIL rst_haddr got %h want 000", HADDR); end
        checks++; if (HSIZE !== 3'b0 || HWRITE !== 1'b0) begin errors++; $display("FAIL rst_hsize_hwrite got %b/%b want 000/0", HSIZE, HWRITE); end
        checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL rst_hwdata got %h want 0", HWDATA); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp got v=%b e=%b d=%h want 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        checks++; if (HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0 || HNONSEC !== 1'b0) begin errors++; $display("FAIL constants got %b/%b/%b/%b want 000/0011/0/0", HBURST, HPROT, HMASTLOCK, HNONSEC); end
    endtask

    task automatic test_single_write();
        settle();
        drive_req(1'b1, 12'h010, 32'hDEADBEEF);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sw_ready got %b want 1", req_ready); end
        tick();
        drive_idle();
        #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 12'h010 || HWRITE !== 1'b1 || HSIZE !== 3'b010) begin errors++; $display("FAIL sw_aphase got tr=%b a=%h w=%b s=%b want 10/010/1/010", HTRANS, HADDR, HWRITE, HSIZE); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sw_rsp_early1 got %b want 0", rsp_valid); end
        tick();
        #1;
        checks++; if (HTRANS !== 2'b00 || HWDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_dphase got tr=%b wd=%h want 00/deadbeef", HTRANS, HWDATA); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sw_rsp_early2 got %b want 0", rsp_valid); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL sw_rsp got v=%b e=%b d=%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sw_rsp_once got %b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd [4];
        rd[0] = 32'h11111111; rd[1] = 32'h22222222;
        rd[2] = 32'h33333333; rd[3] = 32'h44444444;
        settle();
        for (int i = 0; i < 8; i++) begin
            drive_idle();
            if (i < 4) drive_req(1'b0, 12'(4 * i), 32'h0);
            if (i >= 2 && i < 6) HRDATA = rd[i-2];
            #1;
            if (i < 4) begin
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, req_ready); end
            end
            if (i >= 1 && i <= 4) begin
                checks++; if (HTRANS !== 2'b10 || HADDR !== 12'(4 * (i - 1))) begin errors++; $display("FAIL b2b_aphase[%0d] got tr=%b a=%h want 10/%h", i, HTRANS, HADDR, 12'(4 * (i - 1))); end
            end else begin
                checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL b2b_idle[%0d] got %b want 00", i, HTRANS); end
            end
            if (i >= 3 && i <= 6) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== rd[i-3]) begin errors++; $display("FAIL b2b_rsp[%0d] got v=%b e=%b d=%h want 1/0/%h", i, rsp_valid, rsp_err, rsp_rdata, rd[i-3]); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_norsp[%0d] got %b want 0", i, rsp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_wait_states();
        int pulses;
        pulses = 0;
        settle();
        drive_req(1'b1, 12'h030, 32'h12345678);
        tick();
        drive_req(1'b1, 12'h034, 32'hCAFEF00D);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ws_ready_c1 got %b want 1", req_ready); end
        tick();
        for (int c = 2; c <= 5; c++) begin
            drive_idle();
            HREADY = (c == 5);
            #1;
            checks++; if (HWDATA !== 32'h12345678) begin errors++; $display("FAIL ws_hwdata[%0d] got %h want 12345678", c, HWDATA); end
            checks++; if (HTRANS !== 2'b10 || HADDR !== 12'h034) begin errors++; $display("FAIL ws_hold[%0d] got tr=%b a=%h want 10/034", c, HTRANS, HADDR); end
            checks++; if (req_ready !== (c == 5)) begin errors++; $display("FAIL ws_ready[%0d] got %b want %b", c, req_ready, (c == 5)); end
            if (rsp_valid) pulses++;
            tick();
        end
        drive_idle();
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || HWDATA !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_rsp1 got v=%b e=%b wd=%h want 1/0/cafef00d", rsp_valid, rsp_err, HWDATA); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL ws_rsp2 got v=%b e=%b want 1/0", rsp_valid, rsp_err); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b0 || pulses != 0) begin errors++; $display("FAIL ws_extra_rsp got v=%b early=%0d want 0/0", rsp_valid, pulses); end
    endtask

    task automatic test_error_cancel();
        settle();
        drive_req(1'b0, 12'h020, 32'h0);
        tick();
        drive_req(1'b1, 12'h024, 32'h00000055);
        #1;
        checks++; if (req_ready !== 1'b1 || HTRANS !== 2'b10 || HADDR !== 12'h020) begin errors++; $display("FAIL err_c1 got rdy=%b tr=%b a=%h want 1/10/020", req_ready, HTRANS, HADDR); end
        tick();
        drive_idle();
        HREADY = 1'b0; HRESP = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0 || HTRANS !== 2'b10 || HADDR !== 12'h024) begin errors++; $display("FAIL err_first got rdy=%b tr=%b a=%h want 0/10/024", req_ready, HTRANS, HADDR); end
        tick();
        HREADY = 1'b1; HRESP = 1'b1; HRDATA = 32'hDEADDEAD;
        #1;
        checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL err_second got tr=%b v=%b want 00/0", HTRANS, rsp_valid); end
        tick();
        HRESP = 1'b0; HRDATA = 32'h0;
        for (int c = 4; c <= 8; c++) begin
            #1;
            checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL err_reissue[%0d] got tr=%b a=%h want 00", c, HTRANS, HADDR); end
            if (c <= 5) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL err_rsp[%0d] got v=%b e=%b d=%h want 1/1/0", c, rsp_valid, rsp_err, rsp_rdata); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL err_norsp[%0d] got %b want 0", c, rsp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_error_violation();
        settle();
        drive_req(1'b0, 12'h040, 32'h0);
        tick();
        drive_req(1'b0, 12'h044, 32'h0);
        tick();
        drive_idle();
        HRESP = 1'b1; HRDATA = 32'hABABABAB;
        #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 12'h044) begin errors++; $display("FAIL viol_aphase got tr=%b a=%h want 10/044", HTRANS, HADDR); end
        tick();
        HRESP = 1'b0; HRDATA = 32'h00000077;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL viol_rsp1 got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
        tick();
        HRDATA = 32'h0;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h00000077) begin errors++; $display("FAIL viol_rsp2 got v=%b e=%b d=%h want 1/0/00000077", rsp_valid, rsp_err, rsp_rdata); end
    endtask

    task automatic test_align();
        settle();
        drive_req(1'b0, 12'h002, 32'h0);
        tick();
        drive_idle();
        #1;
`ifdef AHB_LITE_INITIATOR_ALIGN_CHK_EN
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL align_aphase got tr=%b want 00", HTRANS); end
`else
        checks++; if (HTRANS !== 2'b10 || HADDR !== 12'h002) begin errors++; $display("FAIL align_aphase got tr=%b a=%h want 10/002", HTRANS, HADDR); end
`endif
        tick();
        HRDATA = 32'h00000099;
        tick();
        HRDATA = 32'h0;
        #1;
`ifdef AHB_LITE_INITIATOR_ALIGN_CHK_EN
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL align_rsp got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
`else
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h00000099) begin errors++; $display("FAIL align_rsp got v=%b e=%b d=%h want 1/0/00000099", rsp_valid, rsp_err, rsp_rdata); end
`endif
    endtask

    task automatic test_reset_mid();
        settle();
        drive_req(1'b0, 12'h050, 32'h0);
        tick();
        drive_idle();
        tick();
        HRDATA = 32'h5A5A5A5A;
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        HRDATA = 32'h0;
        #1;
        checks++; if (HTRANS !== 2'b00 || HADDR !== 12'h0 || req_ready !== 1'b1) begin errors++; $display("FAIL rmid_state got tr=%b a=%h rdy=%b want 00/000/1", HTRANS, HADDR, req_ready); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_norsp[%0d] got %b want 0", c, rsp_valid); end
            tick();
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_wait_states();
        test_error_cancel();
        test_error_violation();
        test_align();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_initiator.md
AHB_LITE_INITIATOR -- requirements
Module: ahb_lite_initiator

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 12, address width; DATA_WIDTH, default 32, data width (8..1024, power of two); NONSEC, default 1'b0, constant value driven on HNONSEC.
REQ-002 SHALL have ports, one per line, as follows.
- HCLK  in  1  the single clock.
- HRESET  in  1  reset, synchronous, active-high.
- req_valid  in  1  client request valid.
- req_ready  out  1  request accepted when high together with req_valid.
- req_write  in  1  write request when 1, read request when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  3  transfer size, AHB HSIZE encoding.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  single-cycle response pulse; the client cannot stall it.
- rsp_rdata  out  DATA_WIDTH  read data, 0 for writes and errors.
- rsp_err  out  1  response is an error.
- HADDR, HSIZE, HWRITE  out  ADDR_WIDTH/3/1  address-phase controls.
- HTRANS  out  2  IDLE=00, NONSEQ=10; no other codes are used.
- HBURST  out  3  constant 000 (SINGLE).
- HPROT  out  4  constant 0011.
- HMASTLOCK  out  1  constant 0.
- HNONSEC  out  1  constant NONSEC.
- HWDATA  out  DATA_WIDTH  data-phase write data.
- HRDATA  in  DATA_WIDTH  read data.
- HREADY  in  1  bus ready.
- HRESP  in  1  0=OKAY, 1=ERROR.

Function
REQ-003 SHALL keep two slots: address slot (A) and data slot (D), each with a valid bit. All AHB outputs SHALL be registered.
REQ-004 req_ready SHALL be combinational, defined as !A_vld | (HREADY & !err1), where err1 = D_vld & HRESP & !HREADY.
REQ-005 On acceptance, the request SHALL load slot A, and HTRANS=NONSEQ, HADDR, HSIZE, HWRITE SHALL show it in the next cycle.
REQ-006 While A_vld=0, HTRANS SHALL be IDLE and HADDR/HSIZE/HWRITE SHALL hold their last values.
REQ-007 When A_vld and HREADY=1 (and !err1), slot A SHALL move to slot D, and HWDATA SHALL present its wdata from the next cycle.
- A new request accepted in the same cycle SHALL overlap back-to-back with no bubble.
REQ-008 HWDATA SHALL stay stable for the whole data phase, including wait states.
REQ-009 When D_vld and HREADY=1, the transfer SHALL complete.
- The next cycle SHALL show rsp_valid=1, rsp_err=HRESP, and rsp_rdata=HRDATA for an OKAY read, else 0.
- Responses SHALL be issued in request order.
REQ-010 Wait states (HREADY=0 with HRESP=0) SHALL hold every slot and output unchanged; the wait count is unbounded.
REQ-011 Two-cycle ERROR: in the first error cycle (err1) with A_vld, the initiator SHALL drive HTRANS=IDLE in the second cycle and mark A as cancelled.
- The cancelled request SHALL report rsp_valid with rsp_err=1 and rsp_rdata=0 one cycle after the errored transfer's response.
- The cancelled request SHALL never be reissued.
REQ-012 An ERROR with HREADY=1 in its first cycle (protocol violation) SHALL still complete the transfer with rsp_err=1, and the next transfer SHALL not be cancelled.
REQ-013 Maximum throughput SHALL be one transfer per cycle with zero-wait slaves; latency from acceptance to rsp_valid SHALL be 3 cycles with zero wait states.

Reset
REQ-014 While HRESET=1 at a HCLK edge:
- A_vld, D_vld, the cancel flag and rsp_valid SHALL be 0.
- HTRANS SHALL be IDLE; HADDR, HSIZE, HWRITE, HWDATA, rsp_rdata and rsp_err SHALL be 0.
- req_ready SHALL be 1 in the first cycle after reset.
REQ-015 A reset mid-transfer SHALL discard all slots and emit no response for them.

Configuration
REQ-016 With macro AHB_LITE_INITIATOR_ALIGN_CHK_EN defined, a request with req_size > log2(DATA_WIDTH/8), or a request whose address is not aligned to its size, SHALL still be accepted and SHALL occupy the slots in order.
- It SHALL drive HTRANS=IDLE in its address phase and produce rsp_err=1 with rsp_rdata=0 at its ordered position.
- Without the macro, every request SHALL be issued unchanged as NONSEQ.

Verification
REQ-017 Single write, addr 0x010, size 010, data 0xDEADBEEF, zero-wait slave -> HTRANS=NONSEQ for 1 cycle, then HWDATA=0xDEADBEEF; rsp_valid 3 cycles after acceptance with rsp_err=0.
REQ-018 Four back-to-back reads, addrs 0x0/0x4/0x8/0xC, zero-wait -> four consecutive NONSEQ cycles and four consecutive rsp_valid pulses carrying the slave data in order.
REQ-019 Write with 3 wait states -> HWDATA stable for all 4 data-phase cycles; req_ready=0 while A_vld; rsp_valid once.
REQ-020 Read at 0x020 gets a two-cycle ERROR while a write to 0x024 is in its address phase -> HTRANS=IDLE in the second error cycle; two rsp_valid pulses both with rsp_err=1; 0x024 is never reissued.
REQ-021 With AHB_LITE_INITIATOR_ALIGN_CHK_EN defined, word read at 0x002 -> no NONSEQ cycle and rsp_err=1; without the macro -> NONSEQ with HADDR=0x002.
REQ-022 HRESET asserted during the data phase of a read -> next cycle HTRANS=IDLE, and rsp_valid stays 0.
